// File: rtl/alu_arbiter_if.sv
// Shared-ALU bus bundle: pipeline port, accelerator request/response port and ALU drive.
// slave = arbiter side, master = environment (pipeline, accelerator, ALU) side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  core_req;
  logic [5:0]            core_ctrl;
  logic [DATA_WIDTH-1:0] core_a;
  logic [DATA_WIDTH-1:0] core_b;
  logic                  core_gnt;
  logic                  core_stall;

  logic                  acc_req;
  logic [5:0]            acc_ctrl;
  logic [DATA_WIDTH-1:0] acc_a;
  logic [DATA_WIDTH-1:0] acc_b;
  logic                  acc_gnt;
  logic                  acc_rsp_valid;
  logic [DATA_WIDTH-1:0] acc_rsp_data;
  logic                  acc_rsp_ready;

  logic [5:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;

  modport slave (
    input  core_req, core_ctrl, core_a, core_b,
    input  acc_req, acc_ctrl, acc_a, acc_b, acc_rsp_ready,
    input  alu_result,
    output core_gnt, core_stall, acc_gnt, acc_rsp_valid, acc_rsp_data,
    output alu_ctrl, alu_a, alu_b
  );

  modport master (
    output core_req, core_ctrl, core_a, core_b,
    output acc_req, acc_ctrl, acc_a, acc_b, acc_rsp_ready,
    output alu_result,
    input  core_gnt, core_stall, acc_gnt, acc_rsp_valid, acc_rsp_data,
    input  alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between the pipeline EX stage and an encryption accelerator (core has priority).
// Define ALU_ARB_STARVE_EN to add the starvation counter that forces an accelerator grant.
//
// state | meaning
// IDLE  | no accelerator response pending
// PEND  | acc_rsp_valid=1, response waiting for acc_rsp_ready
module alu_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("alu_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_t                r_state;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic w_slot_free;
  logic w_force;
  logic w_acc_gnt;
  logic w_core_gnt;
  logic w_core_stall;

  // A response slot drained this cycle can be refilled at the same edge.
  assign w_slot_free = !r_rsp_valid || bus.acc_rsp_ready;
  assign w_acc_gnt   = bus.acc_req && w_slot_free && (!bus.core_req || w_force);
  assign w_core_gnt  = bus.core_req && !w_acc_gnt;

`ifdef ALU_ARB_STARVE_EN
  logic [3:0] r_starve_cnt;

  assign w_force      = (r_starve_cnt == LP_LIMIT);
  assign w_core_stall = bus.core_req && w_acc_gnt;

  // Cycles lost while the slot is full are not counted: the accelerator could not take the ALU anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_acc_gnt || !bus.acc_req) begin
      r_starve_cnt <= 4'd0;
    end else if (w_core_gnt && w_slot_free && (r_starve_cnt != LP_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_force      = (LP_LIMIT == 4'd0);
  assign w_core_stall = 1'b0;
`endif

  always_comb begin
    bus.alu_ctrl = 6'b000000;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    if (w_core_gnt) begin
      bus.alu_ctrl = bus.core_ctrl;
      bus.alu_a    = bus.core_a;
      bus.alu_b    = bus.core_b;
    end else if (w_acc_gnt) begin
      bus.alu_ctrl = bus.acc_ctrl;
      bus.alu_a    = bus.acc_a;
      bus.alu_b    = bus.acc_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_gnt) begin
            r_state     <= PEND;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.alu_result;
          end
        end
        PEND: begin
          if (w_acc_gnt) begin
            r_rsp_data <= bus.alu_result;
          end else if (bus.acc_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_gnt      = w_core_gnt;
  assign bus.core_stall    = w_core_stall;
  assign bus.acc_gnt       = w_acc_gnt;
  assign bus.acc_rsp_valid = r_rsp_valid;
  assign bus.acc_rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised + directed bench for alu_arbiter against a cycle-level reference model.
// Build with or without ALU_ARB_STARVE_EN; the model follows the same macro.
module tb_alu_arbiter;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_alu(logic [5:0] c, logic [DW-1:0] a, logic [DW-1:0] b);
    case (c)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b000010: return a & b;
      6'b000011: return a | b;
      6'b000100: return a ^ b;
      default:   return a + b + 32'd1;
    endcase
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  int n_vec = 0;
  int n_err = 0;

  // reference model: pending response slot and cycles the accelerator has lost in a row
  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_lost;
  bit          m_last_gnt;
  bit          o_acc_gnt;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_data     = '0;
    m_lost     = 0;
    m_last_gnt = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    bit          slot, frc, e_acc, e_core, e_stall;
    logic [5:0]  ec;
    logic [DW-1:0] ea, eb;
    #2;
    slot = !m_valid || bus.acc_rsp_ready;
`ifdef ALU_ARB_STARVE_EN
    frc = (m_lost >= LIMIT);
`else
    frc = 1'b0;
`endif
    e_acc   = bus.acc_req && slot && (!bus.core_req || frc);
    e_core  = bus.core_req && !e_acc;
    e_stall = bus.core_req && e_acc;
    ec = 6'b000000; ea = '0; eb = '0;
    if (e_core) begin
      ec = bus.core_ctrl; ea = bus.core_a; eb = bus.core_b;
    end else if (e_acc) begin
      ec = bus.acc_ctrl; ea = bus.acc_a; eb = bus.acc_b;
    end
    chk("core_gnt",   bus.core_gnt,   e_core);
    chk("acc_gnt",    bus.acc_gnt,    e_acc);
    chk("core_stall", bus.core_stall, e_stall);
    chk("alu_ctrl",   bus.alu_ctrl,   ec);
    chk("alu_a",      bus.alu_a,      ea);
    chk("alu_b",      bus.alu_b,      eb);
    chk("rsp_valid",  bus.acc_rsp_valid, m_valid);
    if (m_valid) chk("rsp_data", bus.acc_rsp_data, m_data);
    o_acc_gnt = bus.acc_gnt;
    @(posedge clk);
    if (e_acc) begin
      m_valid = 1'b1;
      m_data  = ref_alu(ec, ea, eb);
    end else if (bus.acc_rsp_ready) begin
      m_valid = 1'b0;
    end
    if (e_acc || !bus.acc_req) m_lost = 0;
    else if (e_core && slot && m_lost < LIMIT) m_lost++;
    m_last_gnt = e_acc;
    @(negedge clk);
  endtask

  // Core and accelerator both requesting; returns the index of the first accelerator grant (99 = none).
  task automatic contention(output int first);
    bus.core_req = 1'b0; bus.acc_req = 1'b0; bus.acc_rsp_ready = 1'b1;
    step();
    first = 99;
    bus.core_req = 1'b1; bus.core_ctrl = 6'b000001; bus.core_a = 32'd100; bus.core_b = 32'd1;
    bus.acc_req  = 1'b1; bus.acc_ctrl  = 6'b000011; bus.acc_a  = 32'h00F0; bus.acc_b = 32'h0F00;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_acc_gnt && first == 99) first = i;
    end
    bus.core_req = 1'b0; bus.acc_req = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", bus.acc_rsp_valid, 1'b0);
    chk("rst_data",  bus.acc_rsp_data,  '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [5:0] ops [6] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b100111};
  int         first;
`ifdef ALU_ARB_STARVE_EN
  localparam int EXP_FIRST = LIMIT;
`else
  localparam int EXP_FIRST = 99;
`endif

  initial begin
    rst = 1'b1;
    bus.core_req = 1'b0; bus.core_ctrl = '0; bus.core_a = '0; bus.core_b = '0;
    bus.acc_req  = 1'b0; bus.acc_ctrl  = '0; bus.acc_a  = '0; bus.acc_b  = '0;
    bus.acc_rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_valid", bus.acc_rsp_valid, 1'b0);
    chk("reset_data",  bus.acc_rsp_data,  '0);
    @(negedge clk);
    rst = 1'b0;

    // core-only add
    bus.core_req = 1'b1; bus.core_ctrl = 6'b000000; bus.core_a = 32'd5; bus.core_b = 32'd7;
    bus.acc_rsp_ready = 1'b1;
    #1;
    chk("core_add_result", bus.alu_result, 32'd12);
    step();
    chk("core_only_no_rsp", bus.acc_rsp_valid, 1'b0);
    bus.core_req = 1'b0;

    // accelerator-only XOR, response left pending
    bus.acc_req = 1'b1; bus.acc_ctrl = 6'b000100; bus.acc_a = 32'hF0F0_F0F0; bus.acc_b = 32'hFFFF_0000;
    bus.acc_rsp_ready = 1'b0;
    #1;
    chk("acc_only_gnt", bus.acc_gnt, 1'b1);
    step();
    bus.acc_req = 1'b0;
    #1;
    chk("acc_rsp_valid", bus.acc_rsp_valid, 1'b1);
    chk("acc_rsp_xor",   bus.acc_rsp_data,  32'h0F0F_F0F0);
    step();

    // back-pressure, then same-edge replace
    bus.acc_req = 1'b1; bus.acc_ctrl = 6'b100111; bus.acc_a = 32'd1; bus.acc_b = 32'd2;
    #1;
    chk("full_slot_no_gnt", bus.acc_gnt, 1'b0);
    step();
    chk("held_data", bus.acc_rsp_data, 32'h0F0F_F0F0);
    bus.acc_rsp_ready = 1'b1;
    #1;
    chk("refill_gnt", bus.acc_gnt, 1'b1);
    step();
    bus.acc_req = 1'b0;
    #1;
    chk("replace_valid", bus.acc_rsp_valid, 1'b1);
    chk("replace_data",  bus.acc_rsp_data,  32'd4);
    step();

    contention(first);
    chk("starve_grant_cycle", first, EXP_FIRST);

    // reset with a response pending
    bus.acc_req = 1'b1; bus.acc_ctrl = 6'b000000; bus.acc_a = 32'd9; bus.acc_b = 32'd9;
    bus.acc_rsp_ready = 1'b0;
    step();
    bus.acc_req = 1'b0;
    async_reset();

    // reset with lost cycles accumulated, then the full starvation window must be needed again
    bus.acc_rsp_ready = 1'b1; bus.core_req = 1'b1; bus.acc_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    async_reset();
    contention(first);
    chk("starve_after_reset", first, EXP_FIRST);

    for (int n = 0; n < 400; n++) begin
      bus.core_req  = 1'($urandom_range(0, 1));
      bus.core_ctrl = ops[$urandom_range(0, 5)];
      bus.core_a    = $urandom;
      bus.core_b    = $urandom;
      if (!(bus.acc_req && !m_last_gnt)) begin
        bus.acc_req  = 1'($urandom_range(0, 1));
        bus.acc_ctrl = ops[$urandom_range(0, 5)];
        bus.acc_a    = $urandom;
        bus.acc_b    = $urandom;
      end
      bus.acc_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive lost cycles before accelerator is forced a grant (legal 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 core_req  input  1  pipeline EX stage requests ALU this cycle.
REQ-006 core_ctrl / core_a / core_b  input  6 / DATA_WIDTH / DATA_WIDTH  pipeline ALU_Control code and operands.
REQ-007 core_gnt  output  1  pipeline owns ALU this cycle; result read combinationally from alu_result.
REQ-008 core_stall  output  1  pipeline request refused this cycle; EX stage must hold.
REQ-009 acc_req / acc_ctrl / acc_a / acc_b  input  1 / 6 / DATA_WIDTH / DATA_WIDTH  encryption-accelerator request, held stable until acc_gnt.
REQ-010 acc_gnt  output  1  accelerator request accepted this cycle.
REQ-011 acc_rsp_valid / acc_rsp_data  output  1 / DATA_WIDTH  registered accelerator result.
REQ-012 acc_rsp_ready  input  1  accelerator consumes response.
REQ-013 alu_ctrl / alu_a / alu_b  output  6 / DATA_WIDTH / DATA_WIDTH  drive shared ALU.
REQ-014 alu_result  input  DATA_WIDTH  shared ALU result.

Function
REQ-015 Grant decision combinational within the cycle; at most one of core_gnt, acc_gnt high.
REQ-016 Response slot free = !acc_rsp_valid || acc_rsp_ready (single-entry buffer with same-cycle refill).
REQ-017 acc_gnt = acc_req && slot free && (!core_req || force), force = (starve_cnt == STARVE_LIMIT).
REQ-018 core_gnt = core_req && !acc_gnt; core_stall = core_req && acc_gnt.
REQ-019 Mux: core_gnt -> core_* to alu_*; acc_gnt -> acc_* to alu_*; neither -> alu_ctrl 6'b000000, operands 0.
REQ-020 On acc_gnt, acc_rsp_data <= alu_result and acc_rsp_valid <= 1 at that edge (latency 1 cycle).
REQ-021 acc_rsp_valid clears on edge where acc_rsp_ready=1 and no new acc_gnt; data held stable while valid && !ready.
REQ-022 starve_cnt: increments (saturating at STARVE_LIMIT) when acc_req && core_gnt && slot free; clears on acc_gnt or !acc_req; holds when slot not free.
REQ-023 Core never stalled by accelerator while slot not free; core_stall only in forced cycles.
REQ-024 FSM states: IDLE (no response pending), PEND (acc_rsp_valid=1). IDLE->PEND on acc_gnt; PEND->IDLE on ready && !acc_gnt; PEND->PEND on ready && acc_gnt or !ready.
REQ-025 Simultaneous ready and new grant: new result replaces old at same edge, valid stays 1, no bubble.
REQ-026 acc_ctrl 6'b100111 (JALR) or branch codes from accelerator: forwarded unmodified; response carries alu_result only.

Reset
REQ-027 rst high: starve_cnt=0, state IDLE, acc_rsp_valid=0, acc_rsp_data=0 immediately, without clk.
REQ-028 Combinational outputs during reset: grants follow REQ-017/018 with slot free and starve_cnt=0; pending response discarded on reset mid-transaction.

Configuration
REQ-029 Macro ALU_ARB_STARVE_EN defined: starvation counter and forced grant per REQ-017/022.
REQ-030 ALU_ARB_STARVE_EN undefined: no counter, force=0, strict core priority, core_stall tied 0; all else identical.

Verification
REQ-031 core_req=1, acc_req=0, core_ctrl=000000, a=5, b=7 -> core_gnt=1, alu_result 12 seen by core, acc_rsp_valid stays 0.
REQ-032 acc_req=1 alone, acc_ctrl=000100, a=0xF0F0_F0F0, b=0xFFFF_0000 -> acc_gnt same cycle, next cycle acc_rsp_valid=1, data 0x0F0F_F0F0.
REQ-033 core_req and acc_req held high, STARVE_LIMIT=4, macro defined -> core granted 4 cycles, 5th cycle acc_gnt=1, core_stall=1, then counter 0; macro undefined -> acc never granted.
REQ-034 acc_rsp_ready=0 with response pending, acc_req=1, core_req=0 -> acc_gnt=0, data stable; raise ready with acc_req=1 -> same-edge replace, valid stays 1.
REQ-035 rst asserted mid-cycle with acc_rsp_valid=1, starve_cnt=3 -> valid=0, data=0, counter=0 before next clk edge.
